// File: rtl/mc8051_intc_pkg.sv
// Shared constants and helpers for the mc8051 two-level interrupt controller.
package mc8051_intc_pkg;

  localparam int N_SRC_DEF = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    INTC_IDLE = 2'd0,
    INTC_REQ  = 2'd1,
    INTC_HOLD = 2'd2
  } intc_state_e;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [7:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mc8051_intc_if.sv
// Interrupt handshake between the controller (master) and the mc8051 core (slave).
interface mc8051_intc_if;
  logic       int_req_n;
  logic       int_ack_n;
  logic [7:0] int_so_num;
  logic       int_reti;

  modport master (output int_req_n, int_so_num, input  int_ack_n, int_reti);
  modport slave  (input  int_req_n, int_so_num, output int_ack_n, int_reti);
endinterface

// File: rtl/mc8051_intc_arb.sv
// Combinational arbiter: high priority beats low, lowest index wins within a level.
module mc8051_intc_arb
  import mc8051_intc_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic [N_SRC-1:0] cand,
  input  logic [N_SRC-1:0] ip,
  input  logic             isr_hi,
  input  logic             isr_lo,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [7:0] hi_v;
  logic [7:0] lo_v;

  // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    hi_v  = 8'(cand & ip  & {N_SRC{~isr_hi}});
    lo_v  = 8'(cand & ~ip & {N_SRC{~(isr_hi | isr_lo)}});
    valid = (|hi_v) | (|lo_v);
    idx   = (|hi_v) ? lowest_set(hi_v) : lowest_set(lo_v);
  end

endmodule

// File: rtl/mc8051_intc.sv
// Two-level 8051 interrupt controller: edge capture, masking, arbitration and in-service tracking.
module mc8051_intc
  import mc8051_intc_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SRC-1:0]    i_src,
  input  logic [N_SRC-1:0]    i_it,
  input  logic                i_ea,
  input  logic [N_SRC-1:0]    i_ie,
  input  logic [N_SRC-1:0]    i_ip,
  mc8051_intc_if.master       bus,
  output logic [N_SRC-1:0]    o_pend
);

  intc_state_e      state, state_nxt;
  logic [N_SRC-1:0] src_q, pend, pend_nxt, edge_set, req_vec, cand, ack_mask;
  logic             isr_hi, isr_lo, isr_hi_nxt, isr_lo_nxt;
  logic [IDX_W-1:0] so_idx, arb_idx;
  logic             arb_valid, req_ip, req_n;
  logic             load, ack_take, still_ok, cur_ip;
  logic [7:0]       cand8, ip8, ack8;

  mc8051_intc_arb #(.N_SRC(N_SRC)) u_arb (
    .cand   (cand),
    .ip     (i_ip),
    .isr_hi (isr_hi),
    .isr_lo (isr_lo),
    .valid  (arb_valid),
    .idx    (arb_idx)
  );

  always_comb begin
    edge_set = i_it & i_src & ~src_q;
    req_vec  = (i_it & pend) | (~i_it & i_src);
    cand     = req_vec & i_ie & {N_SRC{i_ea}};
    cand8    = 8'(cand);
    ip8      = 8'(i_ip);
    cur_ip   = ip8[so_idx];
    // A priority change on the latched source counts as a withdrawal even if it stays eligible.
    still_ok = cand8[so_idx] && (cur_ip == req_ip) &&
               (req_ip ? !isr_hi : !(isr_hi || isr_lo));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack_take  = 1'b0;
    unique case (state)
      INTC_IDLE: if (arb_valid) begin
        state_nxt = INTC_REQ;
        load      = 1'b1;
      end
      INTC_REQ: begin
        if (!bus.int_ack_n) begin
          state_nxt = INTC_HOLD;
          ack_take  = 1'b1;
        end else if (!still_ok) begin
          state_nxt = INTC_IDLE;
        end
      end
      INTC_HOLD: state_nxt = INTC_IDLE;
      default:   state_nxt = INTC_IDLE;
    endcase
  end

  always_comb begin
    ack8       = ack_take ? (8'd1 << so_idx) : 8'd0;
    ack_mask   = ack8[N_SRC-1:0];
    pend_nxt   = (pend & ~ack_mask) | edge_set;
    isr_hi_nxt = isr_hi;
    isr_lo_nxt = isr_lo;
    // RETI releases the innermost level before the acknowledge claims a level.
    if (bus.int_reti) begin
      if (isr_hi) isr_hi_nxt = 1'b0;
      else        isr_lo_nxt = 1'b0;
    end
    if (ack_take) begin
      if (cur_ip) isr_hi_nxt = 1'b1;
      else        isr_lo_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= INTC_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      pend   <= '0;
      isr_hi <= 1'b0;
      isr_lo <= 1'b0;
      req_n  <= 1'b1;
      so_idx <= '0;
      req_ip <= 1'b0;
    end else begin
      src_q  <= i_src;
      pend   <= pend_nxt;
      isr_hi <= isr_hi_nxt;
      isr_lo <= isr_lo_nxt;
      req_n  <= (state_nxt != INTC_REQ);
      if (load) begin
        so_idx <= arb_idx;
        req_ip <= ip8[arb_idx];
      end
    end
  end

  assign bus.int_req_n  = req_n;
  assign bus.int_so_num = 8'(so_idx);
  assign o_pend         = pend;

endmodule

// File: tb/tb_mc8051_intc.sv
// Directed bench for mc8051_intc with a scoreboard of expected values.
module tb_mc8051_intc;
  import mc8051_intc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src, it, ie, ip, pend;
  logic       ea;

  mc8051_intc_if bus ();

  mc8051_intc #(.N_SRC(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_src  (src),
    .i_it   (it),
    .i_ea   (ea),
    .i_ie   (ie),
    .i_ip   (ip),
    .bus    (bus),
    .o_pend (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; src = '0; it = '0; ie = '0; ip = '0; ea = 1'b0;
    bus.int_ack_n = 1'b1;
    bus.int_reti  = 1'b0;
    tick(); tick();
    expect_v("rst_req_n", 8'd1); expect_v("rst_so_num", 8'h00); expect_v("rst_pend", 8'h00);
    check(8'(bus.int_req_n)); check(bus.int_so_num); check(pend);
    reset = 1'b0;
    ea    = 1'b1;

    // Edge source 2: one-cycle pulse, request two edges later.
    it = 8'h04; ie = 8'h04; ip = 8'h00; src = 8'h04;
    expect_v("edge_pend", 8'h04); expect_v("edge_req_early", 8'd1);
    tick(); src = 8'h00;
    check(pend); check(8'(bus.int_req_n));
    expect_v("edge_req", 8'd0); expect_v("edge_num", 8'h02);
    tick();
    check(8'(bus.int_req_n)); check(bus.int_so_num);
    bus.int_ack_n = 1'b0;
    expect_v("edge_ack_req", 8'd1); expect_v("edge_ack_pend", 8'h00);
    expect_v("edge_isr_lo", 8'd1); expect_v("edge_isr_hi", 8'd0);
    tick(); bus.int_ack_n = 1'b1;
    check(8'(bus.int_req_n)); check(pend); check(8'(dut.isr_lo)); check(8'(dut.isr_hi));
    bus.int_reti = 1'b1;
    expect_v("edge_reti_lo", 8'd0);
    tick(); bus.int_reti = 1'b0;
    check(8'(dut.isr_lo));
    tick();

    // Same-level priority between level sources 1 and 5.
    it = 8'h00; ie = 8'h22; src = 8'h22;
    expect_v("prio_req", 8'd0); expect_v("prio_num1", 8'h01);
    tick();
    check(8'(bus.int_req_n)); check(bus.int_so_num);
    bus.int_ack_n = 1'b0; src = 8'h20;
    tick(); bus.int_ack_n = 1'b1;
    bus.int_reti = 1'b1;
    tick(); bus.int_reti = 1'b0;
    expect_v("prio_req5", 8'd0); expect_v("prio_num5", 8'h05);
    tick();
    check(8'(bus.int_req_n)); check(bus.int_so_num);
    bus.int_ack_n = 1'b0; src = 8'h00;
    tick(); bus.int_ack_n = 1'b1;
    bus.int_reti = 1'b1;
    tick(); bus.int_reti = 1'b0;

    // Nesting: low source 0 in service, high source 3 pre-empts, low source 4 waits.
    ie = 8'h19; ip = 8'h08; src = 8'h01;
    expect_v("nest_num0", 8'h00);
    tick();
    check(bus.int_so_num);
    bus.int_ack_n = 1'b0; src = 8'h09;
    expect_v("nest_isr_lo", 8'd1);
    tick(); bus.int_ack_n = 1'b1;
    check(8'(dut.isr_lo));
    tick();
    expect_v("nest_req3", 8'd0); expect_v("nest_num3", 8'h03);
    tick();
    check(8'(bus.int_req_n)); check(bus.int_so_num);
    bus.int_ack_n = 1'b0; src = 8'h10;
    expect_v("nest_isr_hi", 8'd1);
    tick(); bus.int_ack_n = 1'b1;
    check(8'(dut.isr_hi));
    tick();
    expect_v("nest_blocked", 8'd1);
    tick();
    check(8'(bus.int_req_n));
    bus.int_reti = 1'b1;
    expect_v("nest_reti1", 8'd1);
    tick(); bus.int_reti = 1'b0;
    check(8'(bus.int_req_n));
    expect_v("nest_still_blocked", 8'd1);
    tick();
    check(8'(bus.int_req_n));
    bus.int_reti = 1'b1;
    expect_v("nest_reti2", 8'd1);
    tick(); bus.int_reti = 1'b0;
    check(8'(bus.int_req_n));
    expect_v("nest_req4", 8'd0); expect_v("nest_num4", 8'h04);
    tick();
    check(8'(bus.int_req_n)); check(bus.int_so_num);
    bus.int_ack_n = 1'b0; src = 8'h00;
    tick(); bus.int_ack_n = 1'b1;
    bus.int_reti = 1'b1;
    tick(); bus.int_reti = 1'b0;

    // Withdrawal of level source 6, then drop coinciding with acknowledge.
    ie = 8'h40; ip = 8'h00; src = 8'h40;
    expect_v("wd_req", 8'd0); expect_v("wd_num", 8'h06);
    tick();
    check(8'(bus.int_req_n)); check(bus.int_so_num);
    src = 8'h00;
    expect_v("wd_drop_req", 8'd1); expect_v("wd_isr_lo", 8'd0); expect_v("wd_isr_hi", 8'd0);
    tick();
    check(8'(bus.int_req_n)); check(8'(dut.isr_lo)); check(8'(dut.isr_hi));
    src = 8'h40;
    expect_v("wd2_req", 8'd0);
    tick();
    check(8'(bus.int_req_n));
    src = 8'h00; bus.int_ack_n = 1'b0;
    expect_v("wd2_req_off", 8'd1); expect_v("wd2_isr_lo", 8'd1);
    tick(); bus.int_ack_n = 1'b1;
    check(8'(bus.int_req_n)); check(8'(dut.isr_lo));
    bus.int_reti = 1'b1;
    tick(); bus.int_reti = 1'b0;

    // Simultaneous RETI and acknowledge: low released, high claimed.
    ie = 8'h81; ip = 8'h80; src = 8'h01;
    tick();
    bus.int_ack_n = 1'b0; src = 8'h80;
    tick(); bus.int_ack_n = 1'b1;
    tick();
    expect_v("sim_req", 8'd0); expect_v("sim_num", 8'h07);
    tick();
    check(8'(bus.int_req_n)); check(bus.int_so_num);
    bus.int_ack_n = 1'b0; bus.int_reti = 1'b1;
    expect_v("sim_isr_lo", 8'd0); expect_v("sim_isr_hi", 8'd1);
    tick(); bus.int_ack_n = 1'b1; bus.int_reti = 1'b0;
    check(8'(dut.isr_lo)); check(8'(dut.isr_hi));
    src = 8'h00; bus.int_reti = 1'b1;
    expect_v("sim_reti_hi", 8'd0);
    tick(); bus.int_reti = 1'b0;
    check(8'(dut.isr_hi));

    // Acknowledge outside REQ must not claim a level.
    bus.int_ack_n = 1'b0;
    expect_v("stray_ack_lo", 8'd0); expect_v("stray_ack_hi", 8'd0);
    tick(); bus.int_ack_n = 1'b1;
    check(8'(dut.isr_lo)); check(8'(dut.isr_hi));

    // Reset in the middle of a request.
    it = 8'h04; ie = 8'h04; ip = 8'h00; src = 8'h04;
    tick(); src = 8'h00;
    expect_v("mid_req", 8'd0); expect_v("mid_pend", 8'h04);
    tick();
    check(8'(bus.int_req_n)); check(pend);
    reset = 1'b1;
    expect_v("mid_rst_req", 8'd1); expect_v("mid_rst_num", 8'h00);
    expect_v("mid_rst_pend", 8'h00); expect_v("mid_rst_lo", 8'd0);
    tick(); reset = 1'b0;
    check(8'(bus.int_req_n)); check(bus.int_so_num); check(pend); check(8'(dut.isr_lo));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
